// File: rtl/aes128_cbc_encrypt.sv
// AES-128 encryptor with CBC chaining: one round per clock, ten rounds per block.
// A block is taken on an in_valid/in_ready handshake and held until out_valid/out_ready.
module aes128_cbc_encrypt (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] key_0,
  input  logic [31:0] key_1,
  input  logic [31:0] key_2,
  input  logic [31:0] key_3,
  input  logic [31:0] vector_0,
  input  logic [31:0] vector_1,
  input  logic [31:0] vector_2,
  input  logic [31:0] vector_3,
  input  logic [31:0] plain_text_0,
  input  logic [31:0] plain_text_1,
  input  logic [31:0] plain_text_2,
  input  logic [31:0] plain_text_3,
  input  logic        new_chain,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] cipher_text_0,
  output logic [31:0] cipher_text_1,
  output logic [31:0] cipher_text_2,
  output logic [31:0] cipher_text_3,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        busy
);

  typedef enum logic [1:0] {IDLE, ROUND, DONE} fsm_e;

  // Bit 127 of every 128-bit word is the MSB of AES byte 0.
  localparam logic [0:255][7:0] SBOX = {
    128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
  };

  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

  // SubBytes followed by ShiftRows: output byte (row r, col c) comes from col (c+r)%4.
  function automatic logic [127:0] sub_shift(input logic [127:0] s);
    logic [127:0] r;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        r[127-8*(4*c+row) -: 8] = SBOX[s[127-8*(4*((c+row)%4)+row) -: 8]];
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] mix_columns(input logic [127:0] s);
    logic [127:0] r;
    logic [7:0]   a0, a1, a2, a3;
    r = '0;
    for (int c = 0; c < 4; c++) begin
      a0 = s[127-32*c -: 8];
      a1 = s[119-32*c -: 8];
      a2 = s[111-32*c -: 8];
      a3 = s[103-32*c -: 8];
      r[127-32*c -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
      r[119-32*c -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
      r[111-32*c -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
      r[103-32*c -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    end
    return r;
  endfunction

  function automatic logic [7:0] rcon(input logic [3:0] r);
    logic [7:0] v;
    case (r)
      4'd1:    v = 8'h01;
      4'd2:    v = 8'h02;
      4'd3:    v = 8'h04;
      4'd4:    v = 8'h08;
      4'd5:    v = 8'h10;
      4'd6:    v = 8'h20;
      4'd7:    v = 8'h40;
      4'd8:    v = 8'h80;
      4'd9:    v = 8'h1b;
      4'd10:   v = 8'h36;
      default: v = 8'h00;
    endcase
    return v;
  endfunction

  function automatic logic [127:0] key_expand(input logic [127:0] k, input logic [7:0] rc);
    logic [31:0] t, n0, n1, n2, n3;
    t  = {SBOX[k[23:16]], SBOX[k[15:8]], SBOX[k[7:0]], SBOX[k[31:24]]} ^ {rc, 24'h000000};
    n0 = k[127:96] ^ t;
    n1 = k[95:64]  ^ n0;
    n2 = k[63:32]  ^ n1;
    n3 = k[31:0]   ^ n2;
    return {n0, n1, n2, n3};
  endfunction

  fsm_e         fsm_q, fsm_d;
  logic [127:0] blk_q, blk_d;
  logic [127:0] rkey_q, rkey_d;
  logic [3:0]   round_q, round_d;
  logic [127:0] chain_q, chain_d;
  logic         chain_valid_q, chain_valid_d;
  logic [127:0] ct_q, ct_d;

  logic [127:0] key_in, iv_in, pt_in, chain_src;
  logic [127:0] rkey_next, shifted, round_out;

  assign key_in    = {key_3, key_2, key_1, key_0};
  assign iv_in     = {vector_3, vector_2, vector_1, vector_0};
  assign pt_in     = {plain_text_3, plain_text_2, plain_text_1, plain_text_0};
  assign chain_src = (new_chain || !chain_valid_q) ? iv_in : chain_q;

  assign rkey_next = key_expand(rkey_q, rcon(round_q));
  assign shifted   = sub_shift(blk_q);
  assign round_out = ((round_q == 4'd10) ? shifted : mix_columns(shifted)) ^ rkey_next;

  assign in_ready  = (fsm_q == IDLE);
  assign out_valid = (fsm_q == DONE);
  assign busy      = (fsm_q != IDLE);
  assign {cipher_text_3, cipher_text_2, cipher_text_1, cipher_text_0} = ct_q;

  // NOTE: every _d gets its hold value first so no path through the case infers a latch.
  always_comb begin
    fsm_d         = fsm_q;
    blk_d         = blk_q;
    rkey_d        = rkey_q;
    round_d       = round_q;
    chain_d       = chain_q;
    chain_valid_d = chain_valid_q;
    ct_d          = ct_q;
    case (fsm_q)
      IDLE: begin
        if (in_valid) begin
          blk_d   = pt_in ^ chain_src ^ key_in;
          rkey_d  = key_in;
          round_d = 4'd1;
          fsm_d   = ROUND;
        end
      end
      ROUND: begin
        rkey_d = rkey_next;
        blk_d  = round_out;
        if (round_q == 4'd10) begin
          fsm_d         = DONE;
          ct_d          = round_out;
          chain_d       = round_out;
          chain_valid_d = 1'b1;
        end else begin
          round_d = round_q + 4'd1;
        end
      end
      DONE: begin
        if (out_ready) fsm_d = IDLE;
      end
      default: fsm_d = IDLE;
    endcase
  end

  // NOTE: datapath registers are reset too, so an abandoned block leaves no residue in cipher_text or chain.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      fsm_q         <= IDLE;
      blk_q         <= '0;
      rkey_q        <= '0;
      round_q       <= '0;
      chain_q       <= '0;
      chain_valid_q <= 1'b0;
      ct_q          <= '0;
    end else begin
      // NOTE: non-blocking updates so every register samples the pre-edge values of the others.
      fsm_q         <= fsm_d;
      blk_q         <= blk_d;
      rkey_q        <= rkey_d;
      round_q       <= round_d;
      chain_q       <= chain_d;
      chain_valid_q <= chain_valid_d;
      ct_q          <= ct_d;
    end
  end

endmodule

// File: doc/aes128_cbc_encrypt.md
AES128_CBC_ENCRYPT -- requirements
Module: aes128_cbc_encrypt

Interface
REQ-001 Parameters: none; AES-128, 10 rounds, fixed.
REQ-002 clk  input  1  single clock; all state updates on rising edge.
REQ-003 reset  input  1  asynchronous, active-low; asserted (0) forces reset state immediately, released synchronously to clk by the system.
REQ-004 key_0..key_3  input  32 each  cipher key; key = {key_3,key_2,key_1,key_0}; key bit 127 = AES byte 0 MSB.
REQ-005 vector_0..vector_3  input  32 each  IV, same packing as key.
REQ-006 plain_text_0..plain_text_3  input  32 each  plaintext block, same packing.
REQ-007 new_chain  input  1  qualified by in_valid; 1 = XOR this block with vector, 0 = XOR with previous ciphertext.
REQ-008 in_valid  input  1  plaintext/key/vector/new_chain valid.
REQ-009 in_ready  output  1  block accepted on in_valid & in_ready at rising edge.
REQ-010 cipher_text_0..cipher_text_3  output  32 each  ciphertext, same packing.
REQ-011 out_valid  output  1  cipher_text valid.
REQ-012 out_ready  input  1  consumer takes cipher_text on out_valid & out_ready.
REQ-013 busy  output  1  high while a block is in the round loop or held at the output.

Function
REQ-014 FSM states IDLE, ROUND, DONE; in_ready = 1 only in IDLE; out_valid = 1 only in DONE; busy = (state != IDLE).
REQ-015 IDLE: on accept, key, vector, plaintext and new_chain are sampled; inputs ignored thereafter until the next IDLE.
REQ-016 Chain source on accept: vector if new_chain = 1 or chain_valid = 0; else chain register (last ciphertext).
REQ-017 Accept cycle: state <= plaintext ^ chain_source ^ key; round key <= key; round counter <= 1; go to ROUND.
REQ-018 ROUND, counter r (1..10): round key <= KeyExpand(round key, Rcon[r]); state <= SubBytes, ShiftRows, MixColumns (omitted when r = 10), AddRoundKey with that new round key, all in one cycle.
REQ-019 Rcon[1..10] = 01,02,04,08,10,20,40,80,1b,36; counter is 4 bits and never exceeds 10.
REQ-020 After the r = 10 cycle: go to DONE; cipher_text <= final state; chain register <= final state; chain_valid <= 1.
REQ-021 Latency: block accepted at edge N -> out_valid high after edge N+10; cipher_text stable while out_valid = 1.
REQ-022 DONE: out_valid held until out_valid & out_ready; then go to IDLE; cipher_text retains last value.
REQ-023 Throughput: one block per 12 cycles minimum with out_ready held high; in_valid while not IDLE is ignored, no loss of the in-flight block.
REQ-024 out_ready in IDLE or ROUND has no effect; in_valid and out_ready both high in DONE: only the output handshake occurs.
REQ-025 S-box and xtime arithmetic per FIPS-197, GF(2^8) polynomial 0x11b.

Reset
REQ-026 On reset = 0: state IDLE, in_ready = 1, out_valid = 0, busy = 0, cipher_text_0..3 = 0, chain register = 0, chain_valid = 0, counter = 0, round-key/state registers = 0.
REQ-027 Reset mid-ROUND or in DONE abandons the block; no out_valid; next block uses vector regardless of new_chain.

Verification
REQ-028 FIPS-197: key 000102030405060708090a0b0c0d0e0f, IV 0, new_chain=1, plaintext 00112233445566778899aabbccddeeff -> cipher_text 69c4e0d86a7b0430d8cdb78070b4c55a (cipher_text_3=69c4e0d8, cipher_text_0=70b4c55a), out_valid exactly 10 cycles after accept.
REQ-029 SP800-38A CBC: key 2b7e151628aed2a6abf7158809cf4f3c, IV 000102030405060708090a0b0c0d0e0f; P1 6bc1bee22e409f96e93d7e117393172a new_chain=1 -> 7649abac8119b246cee98e9b12e9197d; P2 ae2d8a571e03ac9c9eb76fac45af8e51 new_chain=0 -> 5086cb9b507219ee95db113a917678b2.
REQ-030 Backpressure: out_ready=0 for 20 cycles in DONE -> out_valid and cipher_text held, in_ready=0, in_valid pulses ignored; out_ready=1 -> IDLE next cycle.
REQ-031 Chain restart: after REQ-029 P1, resend P1 with new_chain=1 -> 7649abac8119b246cee98e9b12e9197d again.
REQ-032 Reset at round 5 of P2, release, send P2 with new_chain=0 -> XOR uses IV (chain_valid=0); result equals single-block encryption of P2 with that IV; no spurious out_valid.
